// File: rtl/alt_ddrx_sched_pkg.sv
// Shared definitions for the DDR2 read/write scheduler: state encoding,
// gap counter width and the memory-clock to controller-clock conversion.
package alt_ddrx_sched_pkg;

  // Gap arithmetic width; holds the worst case CL15 + AL7 turnaround.
  localparam int GAP_W = 7;

  // Direction of the most recent issue.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAST_RD = 2'd1,
    ST_LAST_WR = 2'd2
  } sched_state_t;

  // Memory clocks to controller clocks, rounded up: ceil(mem / (ratio/2)).
  function automatic logic [GAP_W-1:0] mem_to_ctl(input logic [GAP_W-1:0] mem_gap,
                                                  input int ratio);
    int div;
    div = (ratio >= 4) ? ratio / 2 : 1;
    return GAP_W'((int'(mem_gap) + div - 1) / div);
  endfunction

  // Load value for a gap counter: gap - 1, floored at zero.
  function automatic logic [GAP_W-1:0] gap_load(input logic [GAP_W-1:0] gap);
    return (gap == '0) ? '0 : gap - GAP_W'(1);
  endfunction

endpackage

// File: rtl/alt_ddrx_gap_timer.sv
// Loadable down-counter that saturates at zero; zero flag marks the end of a gap.
module alt_ddrx_gap_timer
  import alt_ddrx_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero
);

  logic [GAP_W-1:0] count;

  // Load on issue, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - GAP_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alt_ddrx_ddr2_rdwr_sched.sv
// DDR2 read/write command scheduler. Arbitrates between one read and one
// write requester, spaces issues by same-direction and turnaround gaps and
// limits same-direction streaks while the other side waits.
//
// Two gap timers are loaded on every issue: one with the same-direction gap
// and one with the turnaround gap for the direction just issued. The next
// issue waits on whichever timer matches its direction, so back-to-back
// same-direction traffic is not slowed by the longer turnaround. busy
// reflects the turnaround timer, which always covers the longer gap.
module alt_ddrx_ddr2_rdwr_sched
  import alt_ddrx_sched_pkg::*;
#(
  parameter int DWIDTH_RATIO       = 2,
  parameter int MEMORY_BURSTLENGTH = 8,
  parameter int ADD_LAT_BUS_WIDTH  = 3,
  parameter int TCL_BUS_WIDTH      = 4,
  parameter int TWTR_CK            = 2,
  parameter int STREAK_MAX         = 4
) (
  input  logic                         ctl_clk,
  input  logic                         ctl_reset_n,
  input  logic [TCL_BUS_WIDTH-1:0]     mem_tcl,
  input  logic [ADD_LAT_BUS_WIDTH-1:0] mem_add_lat,
  input  logic                         rd_req,
  input  logic                         wr_req,
  output logic                         rd_grant,
  output logic                         wr_grant,
  output logic                         do_read,
  output logic                         do_write,
  output logic                         busy
);

  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);
  localparam logic [GAP_W-1:0]    HALF_BL    = GAP_W'(MEMORY_BURSTLENGTH / 2);
  localparam logic [GAP_W-1:0]    TWTR       = GAP_W'(TWTR_CK);

  sched_state_t        state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;

  logic [GAP_W-1:0] mem_same, mem_rtw, mem_wtr;
  logic [GAP_W-1:0] gap_same, gap_rtw, gap_wtr;
  logic [GAP_W-1:0] turn_load;
  logic             same_zero, turn_zero;
  logic             rd_ok, wr_ok, pick_rd, pick_wr;
  logic             issue_rd, issue_wr, issue;

  // Gaps in memory clocks.
  always_comb begin
    mem_same = HALF_BL;
    mem_rtw  = HALF_BL + GAP_W'(2);
    mem_wtr  = GAP_W'(mem_tcl) + GAP_W'(mem_add_lat) - GAP_W'(1) + HALF_BL + TWTR;
  end

  // Converted gaps registered once; configuration is quasi-static.
  always_ff @(posedge ctl_clk) begin
    gap_same <= mem_to_ctl(mem_same, DWIDTH_RATIO);
    gap_rtw  <= mem_to_ctl(mem_rtw, DWIDTH_RATIO);
    gap_wtr  <= mem_to_ctl(mem_wtr, DWIDTH_RATIO);
  end

  assign issue     = issue_rd | issue_wr;
  assign turn_load = issue_rd ? gap_load(gap_rtw) : gap_load(gap_wtr);

  alt_ddrx_gap_timer same_timer (
    .clk      (ctl_clk),
    .rst_n    (ctl_reset_n),
    .load     (issue),
    .load_val (gap_load(gap_same)),
    .zero     (same_zero)
  );

  alt_ddrx_gap_timer turn_timer (
    .clk      (ctl_clk),
    .rst_n    (ctl_reset_n),
    .load     (issue),
    .load_val (turn_load),
    .zero     (turn_zero)
  );

  // Arbitration, issue qualification, next state and streak update.
  always_comb begin
    pick_rd    = 1'b0;
    pick_wr    = 1'b0;
    state_nxt  = state;
    streak_nxt = streak;

    rd_ok = (state == ST_LAST_WR) ? turn_zero : same_zero;
    wr_ok = (state == ST_LAST_RD) ? turn_zero : same_zero;

    if (rd_req && wr_req) begin
      unique case (state)
        ST_LAST_RD: if (streak == STREAK_LIM) pick_wr = 1'b1; else pick_rd = 1'b1;
        ST_LAST_WR: if (streak == STREAK_LIM) pick_rd = 1'b1; else pick_wr = 1'b1;
        default:    pick_rd = 1'b1;
      endcase
    end else begin
      pick_rd = rd_req;
      pick_wr = wr_req;
    end

    issue_rd = pick_rd & rd_ok;
    issue_wr = pick_wr & wr_ok;

    if (issue_rd) begin
      state_nxt = ST_LAST_RD;
      if (!wr_req)                 streak_nxt = '0;
      else if (state != ST_LAST_RD) streak_nxt = STREAK_W'(1);
      else                          streak_nxt = streak + STREAK_W'(1);
    end else if (issue_wr) begin
      state_nxt = ST_LAST_WR;
      if (!rd_req)                 streak_nxt = '0;
      else if (state != ST_LAST_WR) streak_nxt = STREAK_W'(1);
      else                          streak_nxt = streak + STREAK_W'(1);
    end
  end

  // Control state and registered grant strobes.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state    <= ST_IDLE;
      streak   <= '0;
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
    end else begin
      state    <= state_nxt;
      streak   <= streak_nxt;
      rd_grant <= issue_rd;
      wr_grant <= issue_wr;
    end
  end

  assign do_read  = rd_grant;
  assign do_write = wr_grant;
  assign busy     = ~turn_zero;

endmodule

// File: tb/tb_alt_ddrx_ddr2_rdwr_sched.sv
// Bench for the DDR2 read/write scheduler: one full-rate and one half-rate
// instance, requesters modelled as command counts, grants scoreboarded by
// cycle number.
module tb_alt_ddrx_ddr2_rdwr_sched;

  typedef struct packed {
    logic        inst;
    logic        wr;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] mem_tcl;
  logic [2:0] mem_add_lat;
  logic [1:0] rd_req, wr_req, rd_grant, wr_grant, do_read, do_write, busy;

  int  rd_left [2];
  int  wr_left [2];
  int  cyc, checks, errors, mirror_bad;
  ev_t exp_q[$];
  ev_t obs_q[$];

  always #5 clk = ~clk;

  alt_ddrx_ddr2_rdwr_sched #(.DWIDTH_RATIO(2)) dut_full (
    .ctl_clk(clk), .ctl_reset_n(rst_n), .mem_tcl(mem_tcl), .mem_add_lat(mem_add_lat),
    .rd_req(rd_req[0]), .wr_req(wr_req[0]), .rd_grant(rd_grant[0]), .wr_grant(wr_grant[0]),
    .do_read(do_read[0]), .do_write(do_write[0]), .busy(busy[0])
  );

  alt_ddrx_ddr2_rdwr_sched #(.DWIDTH_RATIO(4)) dut_half (
    .ctl_clk(clk), .ctl_reset_n(rst_n), .mem_tcl(mem_tcl), .mem_add_lat(mem_add_lat),
    .rd_req(rd_req[1]), .wr_req(wr_req[1]), .rd_grant(rd_grant[1]), .wr_grant(wr_grant[1]),
    .do_read(do_read[1]), .do_write(do_write[1]), .busy(busy[1])
  );

  function automatic ev_t mk(input logic inst, input logic wr, input int c);
    ev_t e;
    e.inst = inst;
    e.wr   = wr;
    e.cyc  = 32'(c);
    return e;
  endfunction

  // Advance one cycle: drive request levels, sample outputs 1 after the edge,
  // record grants and let the requesters drop on grant.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      rd_req[i] = (rd_left[i] > 0);
      wr_req[i] = (wr_left[i] > 0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (do_read !== rd_grant || do_write !== wr_grant || (rd_grant & wr_grant) !== 2'b00)
      mirror_bad++;
    for (int i = 0; i < 2; i++) begin
      if (rd_grant[i] === 1'b1) begin
        obs_q.push_back(mk(i == 1, 1'b0, cyc));
        if (rd_left[i] > 0) rd_left[i]--;
      end
      if (wr_grant[i] === 1'b1) begin
        obs_q.push_back(mk(i == 1, 1'b1, cyc));
        if (wr_left[i] > 0) wr_left[i]--;
      end
      rd_req[i] = (rd_left[i] > 0);
      wr_req[i] = (wr_left[i] > 0);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 3) rst_n = 1'b1;
      step();
      checks++;
      if ({rd_grant, wr_grant, do_read, do_write, busy} !== 10'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b, required 0", cyc,
                 {rd_grant, wr_grant, do_read, do_write, busy});
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_grants: got %0d grants, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_full_rate();
    int  t0;
    ev_t e, o;
    // Reads held: gap 4.
    t0 = cyc; rd_left[0] = 3;
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 1));
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 5));
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 9));
    repeat (20) step();
    // Read then write: read-to-write gap 6.
    t0 = cyc; rd_left[0] = 1; wr_left[0] = 1;
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 1));
    exp_q.push_back(mk(1'b0, 1'b1, t0 + 7));
    repeat (20) step();
    // Write then read: write-to-read gap 9.
    t0 = cyc; rd_left[0] = 1; wr_left[0] = 1;
    exp_q.push_back(mk(1'b0, 1'b1, t0 + 1));
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 10));
    repeat (20) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL full_rate grant: got none, required wr=%0d @%0d", e.wr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL full_rate grant: got inst%0d wr=%0d @%0d, required inst%0d wr=%0d @%0d",
                   o.inst, o.wr, o.cyc, e.inst, e.wr, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL full_rate extra: got %0d grants, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_half_rate();
    int  t0;
    ev_t e, o;
    t0 = cyc; rd_left[1] = 2;
    exp_q.push_back(mk(1'b1, 1'b0, t0 + 1));
    exp_q.push_back(mk(1'b1, 1'b0, t0 + 3));
    repeat (15) step();
    t0 = cyc; rd_left[1] = 1; wr_left[1] = 1;
    exp_q.push_back(mk(1'b1, 1'b0, t0 + 1));
    exp_q.push_back(mk(1'b1, 1'b1, t0 + 4));
    repeat (15) step();
    t0 = cyc; rd_left[1] = 1; wr_left[1] = 1;
    exp_q.push_back(mk(1'b1, 1'b1, t0 + 1));
    exp_q.push_back(mk(1'b1, 1'b0, t0 + 6));
    repeat (15) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL half_rate grant: got none, required wr=%0d @%0d", e.wr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL half_rate grant: got inst%0d wr=%0d @%0d, required inst%0d wr=%0d @%0d",
                   o.inst, o.wr, o.cyc, e.inst, e.wr, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL half_rate extra: got %0d grants, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_streak();
    int  t0;
    ev_t e, o;
    // Expected direction and offset of each grant with both sides pending.
    logic wr_seq [14] = '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1, 0};
    int   off_seq[14] = '{1,5,9,13, 19,23,27,31, 40,44,48,52, 58, 67};
    t0 = cyc; rd_left[0] = 1;
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 1));
    repeat (15) step();
    t0 = cyc; rd_left[0] = 9; wr_left[0] = 5;
    for (int k = 0; k < 14; k++) exp_q.push_back(mk(1'b0, wr_seq[k], t0 + off_seq[k]));
    repeat (80) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL streak grant: got none, required wr=%0d @%0d", e.wr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL streak grant: got inst%0d wr=%0d @%0d, required inst%0d wr=%0d @%0d",
                   o.inst, o.wr, o.cyc, e.inst, e.wr, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL streak extra: got %0d grants, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_max_latency();
    int  t0;
    ev_t e, o;
    mem_tcl = 4'd15; mem_add_lat = 3'd7;
    repeat (3) step();
    t0 = cyc; wr_left[0] = 1;
    exp_q.push_back(mk(1'b0, 1'b1, t0 + 1));
    exp_q.push_back(mk(1'b0, 1'b0, t0 + 28));
    step();
    rd_left[0] = 1;
    for (int k = 1; k <= 27; k++) begin
      if (k > 1) step();
      checks++;
      if (busy[0] !== (k <= 26)) begin
        errors++;
        $display("FAIL max_lat_busy cycle +%0d: got %b, required %b", k, busy[0], (k <= 26));
      end
    end
    repeat (12) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL max_lat grant: got none, required wr=%0d @%0d", e.wr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL max_lat grant: got inst%0d wr=%0d @%0d, required inst%0d wr=%0d @%0d",
                   o.inst, o.wr, o.cyc, e.inst, e.wr, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL max_lat extra: got %0d grants, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_gap();
    int  t0, tr;
    ev_t e, o;
    t0 = cyc; wr_left[0] = 1;
    exp_q.push_back(mk(1'b0, 1'b1, t0 + 1));
    repeat (3) step();
    rst_n = 1'b0;
    rd_left[0] = 1;
    #1;
    checks++;
    if ({rd_grant, wr_grant, do_read, do_write, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_gap outputs: got %b, required 0",
               {rd_grant, wr_grant, do_read, do_write, busy});
    end
    repeat (2) step();
    rst_n = 1'b1;
    tr = cyc;
    exp_q.push_back(mk(1'b0, 1'b0, tr + 1));
    repeat (15) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_mid_gap grant: got none, required wr=%0d @%0d", e.wr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_mid_gap grant: got inst%0d wr=%0d @%0d, required inst%0d wr=%0d @%0d",
                   o.inst, o.wr, o.cyc, e.inst, e.wr, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_gap extra: got %0d grants, required 0", obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (mirror_bad !== 0) begin
      errors++;
      $display("FAIL strobe_mirror: got %0d bad cycles, required 0", mirror_bad);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_tcl     = 4'd4;
    mem_add_lat = 3'd0;
    rd_req      = 2'b00;
    wr_req      = 2'b00;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    mirror_bad  = 0;
    for (int i = 0; i < 2; i++) begin
      rd_left[i] = 0;
      wr_left[i] = 0;
    end
    test_reset();
    test_full_rate();
    test_half_rate();
    test_streak();
    test_max_latency();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
